// File: rtl/cvxif_instr_pkg.sv
// Custom-0 instruction encodings, queue entry layout and queue states for the coprocessor.
package cvxif_instr_pkg;

  localparam logic [6:0] OpcodeCustom0 = 7'b0001011;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    XOR  = 3'b010,
    NOP  = 3'b011,
    EXC  = 3'b100,
    ADD3 = 3'b101
  } copro_op_e;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } queue_state_e;

  typedef struct packed {
    logic [cvxif_pkg::X_ID_WIDTH-1:0] id;
    logic [4:0]                       rd;
    copro_op_e                        op;
    logic [riscv::XLEN-1:0]           rs1;
    logic [riscv::XLEN-1:0]           rs2;
    logic [riscv::XLEN-1:0]           rs3;
    logic                             committed;
    logic                             killed;
  } copro_entry_t;

  function automatic logic op_writes_rd(input copro_op_e op);
    case (op)
      ADD, SUB, XOR, ADD3: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cvxif_pkg.sv
// CoreV-X-Interface request/response types between the core's CVXIF unit and a coprocessor.
package cvxif_pkg;

  localparam int unsigned X_NUM_RS    = 3;
  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFR_WIDTH = riscv::XLEN;
  localparam int unsigned X_RFW_WIDTH = riscv::XLEN;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef struct packed {
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    x_commit_t    x_commit;
    logic         x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/riscv.sv
// Minimal RISC-V architectural constants used by the CVXIF coprocessor slice.
package riscv;

  localparam int unsigned XLEN          = 32;
  localparam logic [5:0]  ILLEGAL_INSTR = 6'd2;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational custom-0 decoder: accept/writeback/exception flags and operation for one instruction.
module cvxif_copro_decoder
  import cvxif_instr_pkg::*;
(
  input  logic [31:0]                      instr,
  input  logic [cvxif_pkg::X_NUM_RS-1:0]   rs_valid,
  output logic                             accept,
  output logic                             we,
  output logic                             exc,
  output copro_op_e                        op
);

  logic unused_instr_s;
  assign unused_instr_s = ^{instr[31:15], instr[11:7]};

  // Opcode/funct3 lookup; unlisted combinations are rejected.
  always_comb begin
    accept = 1'b0;
    exc    = 1'b0;
    op     = NOP;
    if (instr[6:0] == OpcodeCustom0) begin
      case (instr[14:12])
        3'b000:  begin op = ADD; accept = 1'b1; end
        3'b001:  begin op = SUB; accept = 1'b1; end
        3'b010:  begin op = XOR; accept = 1'b1; end
        3'b011:  begin op = NOP; accept = 1'b1; end
        3'b100:  begin op = EXC; accept = 1'b1; exc = 1'b1; end
        3'b101:  begin
          op     = ADD3;
          accept = (cvxif_pkg::X_NUM_RS == 32'd3) && (&rs_valid);
        end
        default: begin op = NOP; accept = 1'b0; end
      endcase
    end else begin
      accept = 1'b0;
    end
    we = accept && op_writes_rd(op);
  end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CVXIF coprocessor responder: decode at issue, in-order queue awaiting commit/kill,
// execute at the head and return results through a single result register.
module cvxif_copro_responder
  import cvxif_pkg::*;
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  cvxif_req_t  cvxif_req_i,
  output cvxif_resp_t cvxif_resp_o
);

  localparam int unsigned     PtrW    = $clog2(FifoDepth);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

  copro_entry_t       entries_r [FifoDepth];
  logic [PtrW-1:0]    wr_ptr_r, rd_ptr_r, offset_s;
  logic [CntW-1:0]    count_r, count_next_s;
  queue_state_e       state_r, state_next_s;
  logic               res_valid_r;
  x_result_t          res_r, exec_s;

  logic               dec_accept_s, dec_we_s, dec_exc_s;
  copro_op_e          dec_op_s;
  logic               issue_ready_s, push_s, pop_s, load_s, drain_s, push_commit_s;
  logic [FifoDepth-1:0] entry_valid_s, commit_hit_s;
  copro_entry_t       head_s, push_entry_s;

  cvxif_copro_decoder u_decoder (
    .instr    (cvxif_req_i.x_issue_req.instr),
    .rs_valid (cvxif_req_i.x_issue_req.rs_valid),
    .accept   (dec_accept_s),
    .we       (dec_we_s),
    .exc      (dec_exc_s),
    .op       (dec_op_s)
  );

  // Issue ready is a pure function of occupancy, never of same-cycle pops.
  assign issue_ready_s = (state_r != FULL);
  assign push_s        = cvxif_req_i.x_issue_valid && issue_ready_s && dec_accept_s;
  assign head_s        = entries_r[rd_ptr_r];

  // Occupancy mask and commit id search, including bypass onto the entry being pushed.
  always_comb begin
    entry_valid_s = {FifoDepth{1'b0}};
    commit_hit_s  = {FifoDepth{1'b0}};
    offset_s      = {PtrW{1'b0}};
    for (int i = 0; i < FifoDepth; i++) begin
      offset_s         = PtrW'(i) - rd_ptr_r;
      entry_valid_s[i] = ({1'b0, offset_s} < count_r);
      commit_hit_s[i]  = entry_valid_s[i] && cvxif_req_i.x_commit_valid &&
                         (entries_r[i].id == cvxif_req_i.x_commit.id);
    end
    push_commit_s = cvxif_req_i.x_commit_valid &&
                    (cvxif_req_i.x_commit.id == cvxif_req_i.x_issue_req.id);

    push_entry_s.id        = cvxif_req_i.x_issue_req.id;
    push_entry_s.rd        = cvxif_req_i.x_issue_req.instr[11:7];
    push_entry_s.op        = dec_op_s;
    push_entry_s.rs1       = cvxif_req_i.x_issue_req.rs[0];
    push_entry_s.rs2       = cvxif_req_i.x_issue_req.rs[1];
    push_entry_s.rs3       = cvxif_req_i.x_issue_req.rs[X_NUM_RS-1];
    push_entry_s.committed = push_commit_s && !cvxif_req_i.x_commit.x_commit_kill;
    push_entry_s.killed    = push_commit_s && cvxif_req_i.x_commit.x_commit_kill;
  end

  // Head handling: killed entries drop silently, committed ones move into the result register.
  always_comb begin
    drain_s = res_valid_r && cvxif_req_i.x_result_ready;
    pop_s   = 1'b0;
    load_s  = 1'b0;
    if (state_r != EMPTY) begin
      if (head_s.killed) begin
        pop_s = 1'b1;
      end else if (head_s.committed && (!res_valid_r || drain_s)) begin
        pop_s  = 1'b1;
        load_s = 1'b1;
      end else begin
        pop_s  = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Execute unit on the head entry; arithmetic wraps at XLEN.
  always_comb begin
    exec_s.id      = head_s.id;
    exec_s.rd      = head_s.rd;
    exec_s.we      = op_writes_rd(head_s.op);
    exec_s.exc     = (head_s.op == EXC);
    exec_s.exccode = (head_s.op == EXC) ? riscv::ILLEGAL_INSTR : 6'd0;
    case (head_s.op)
      ADD:     exec_s.data = head_s.rs1 + head_s.rs2;
      SUB:     exec_s.data = head_s.rs1 - head_s.rs2;
      XOR:     exec_s.data = head_s.rs1 ^ head_s.rs2;
      ADD3:    exec_s.data = head_s.rs1 + head_s.rs2 + head_s.rs3;
      default: exec_s.data = {X_RFW_WIDTH{1'b0}};
    endcase
  end

  // Occupancy bookkeeping and queue state transitions.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CntW'(1'b1);
      2'b01:   count_next_s = count_r - CntW'(1'b1);
      default: count_next_s = count_r;
    endcase
    state_next_s = state_r;
    case (state_r)
      EMPTY:   state_next_s = push_s ? ACTIVE : EMPTY;
      ACTIVE: begin
        if (count_next_s == CntFull)                state_next_s = FULL;
        else if (count_next_s == {CntW{1'b0}})      state_next_s = EMPTY;
        else                                        state_next_s = ACTIVE;
      end
      FULL:    state_next_s = pop_s ? ACTIVE : FULL;
      default: state_next_s = EMPTY;
    endcase
  end

  // Queue storage: new entry on push, commit/kill flag on a matching id.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) entries_r[i] <= '0;
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        if (push_s && (wr_ptr_r == PtrW'(i))) begin
          entries_r[i] <= push_entry_s;
        end else if (commit_hit_s[i]) begin
          if (cvxif_req_i.x_commit.x_commit_kill) entries_r[i].killed    <= 1'b1;
          else                                    entries_r[i].committed <= 1'b1;
        end
      end
    end
  end

  // Pointers, count, state and the result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= {PtrW{1'b0}};
      rd_ptr_r    <= {PtrW{1'b0}};
      count_r     <= {CntW{1'b0}};
      state_r     <= EMPTY;
      res_valid_r <= 1'b0;
      res_r       <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1'b1);
      count_r <= count_next_s;
      state_r <= state_next_s;
      if (load_s) begin
        res_valid_r <= 1'b1;
        res_r       <= exec_s;
      end else if (drain_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  // Issue response is gated by issue_valid; result fields come straight from the register.
  always_comb begin
    cvxif_resp_o               = '0;
    cvxif_resp_o.x_issue_ready = issue_ready_s;
    if (cvxif_req_i.x_issue_valid) begin
      cvxif_resp_o.x_issue_resp.accept    = dec_accept_s;
      cvxif_resp_o.x_issue_resp.writeback = dec_we_s;
      cvxif_resp_o.x_issue_resp.exc       = dec_exc_s;
    end else begin
      cvxif_resp_o.x_issue_resp = '0;
    end
    cvxif_resp_o.x_result_valid = res_valid_r;
    cvxif_resp_o.x_result       = res_r;
  end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Scoreboard bench for cvxif_copro_responder: directed issue/commit vectors, monitor checks results.
module tb_cvxif_copro_responder;
  import cvxif_pkg::*;

  logic        clk;
  logic        rst_n;
  cvxif_req_t  req;
  cvxif_resp_t resp;

  int          n_tests = 0;
  int          n_fail  = 0;
  x_result_t   exp_q[$];
  x_result_t   mon_exp;

  cvxif_copro_responder #(.FifoDepth(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cvxif_req_i  (req),
    .cvxif_resp_o (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && resp.x_result_valid && req.x_result_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h expected none",
                 resp.x_result.id, resp.x_result.data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 64'(resp.x_result), 64'(mon_exp));
      end
    end
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    req.x_issue_valid  = 1'b0;
    req.x_commit_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [2:0] rsv);
    req.x_issue_valid          = 1'b1;
    req.x_issue_req.instr      = instr;
    req.x_issue_req.id         = id;
    req.x_issue_req.rs[0]      = a;
    req.x_issue_req.rs[1]      = b;
    req.x_issue_req.rs[2]      = c;
    req.x_issue_req.rs_valid   = rsv;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    req.x_commit_valid         = 1'b1;
    req.x_commit.id            = id;
    req.x_commit.x_commit_kill = kill;
  endtask

  task automatic expect_res(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                            input logic we, input logic exc, input logic [5:0] code);
    x_result_t e;
    e.id = id; e.data = data; e.rd = rd; e.we = we; e.exc = exc; e.exccode = code;
    exp_q.push_back(e);
  endtask

  task automatic check_issue(input string name, input logic acc, input logic wb, input logic ex);
    #1;
    check({name, "_accept"}, 64'(resp.x_issue_resp.accept), 64'(acc));
    check({name, "_writeback"}, 64'(resp.x_issue_resp.writeback), 64'(wb));
    check({name, "_exc"}, 64'(resp.x_issue_resp.exc), 64'(ex));
    check({name, "_dual_ls"}, 64'({resp.x_issue_resp.dualwrite, resp.x_issue_resp.dualread,
                                   resp.x_issue_resp.loadstore}), 64'(0));
  endtask

  initial begin
    req   = '0;
    req.x_result_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_ready", 64'(resp.x_issue_ready), 64'(1));
    check("rst_result_valid", 64'(resp.x_result_valid), 64'(0));
    check("rst_resp_zero", 64'({resp.x_issue_resp, resp.x_result}), 64'(0));
    rst_n = 1'b1;

    // Basic ADD with same-cycle commit: result two cycles later
    step();
    issue(32'h0000_050B, 4'd3, 32'd5, 32'd7, 32'd0, 3'b011);
    commit(4'd3, 1'b0);
    expect_res(4'd3, 32'd12, 5'd10, 1'b1, 1'b0, 6'd0);
    check_issue("add", 1'b1, 1'b1, 1'b0);
    step();
    check("add_lat_t1", 64'(resp.x_result_valid), 64'(0));
    step();
    check("add_lat_t2", 64'(resp.x_result_valid), 64'(1));

    // Rejections and the remaining accepted operations
    step();
    issue(32'h0000_0033, 4'd5, 32'd1, 32'd1, 32'd0, 3'b011);
    commit(4'd5, 1'b0);
    check_issue("rej_opcode", 1'b0, 1'b0, 1'b0);
    step();
    issue(mk(3'b110, 5'd1), 4'd5, 32'd1, 32'd1, 32'd0, 3'b011);
    check_issue("rej_f3", 1'b0, 1'b0, 1'b0);
    step();
    issue(32'h0000_508B, 4'd5, 32'd1, 32'd2, 32'd3, 3'b011);
    check_issue("rej_add3", 1'b0, 1'b0, 1'b0);
    step();
    issue(32'h0000_400B, 4'd6, 32'd9, 32'd9, 32'd0, 3'b011);
    commit(4'd6, 1'b0);
    expect_res(4'd6, 32'd0, 5'd0, 1'b0, 1'b1, 6'd2);
    check_issue("exc", 1'b1, 1'b0, 1'b1);
    step();
    issue(32'h0000_508B, 4'd7, 32'd1, 32'd2, 32'd3, 3'b111);
    commit(4'd7, 1'b0);
    expect_res(4'd7, 32'd6, 5'd1, 1'b1, 1'b0, 6'd0);
    check_issue("add3", 1'b1, 1'b1, 1'b0);
    step();
    issue(32'h0000_320B, 4'd8, 32'd4, 32'd4, 32'd0, 3'b011);
    commit(4'd8, 1'b0);
    expect_res(4'd8, 32'd0, 5'd4, 1'b0, 1'b0, 6'd0);
    check_issue("nop", 1'b1, 1'b0, 1'b0);
    step();
    issue(mk(3'b000, 5'd9), 4'd9, 32'd1, 32'd1, 32'd0, 3'b011);
    commit(4'd9, 1'b1);
    repeat (6) step();

    // Full queue: four uncommitted entries stall issue until the head pops
    for (int k = 0; k < 4; k++) begin
      step();
      issue(32'h0000_010B, 4'(k), 32'(16 * k), 32'd1, 32'd0, 3'b011);
      expect_res(4'(k), 32'(16 * k + 1), 5'd2, 1'b1, 1'b0, 6'd0);
      #1;
      check("full_ready_before", 64'(resp.x_issue_ready), 64'(1));
    end
    step();
    commit(4'd0, 1'b0);
    #1;
    check("full_ready_low", 64'(resp.x_issue_ready), 64'(0));
    step();
    check("full_ready_t1", 64'(resp.x_issue_ready), 64'(0));
    step();
    check("full_ready_t2", 64'(resp.x_issue_ready), 64'(1));
    for (int k = 1; k < 4; k++) begin
      step();
      commit(4'(k), 1'b0);
    end
    repeat (6) step();

    // Kill the middle entry; only ids 1 and 3 return, in order
    for (int k = 1; k < 4; k++) begin
      step();
      issue(32'h0000_218B, 4'(k), 32'hF0F0_0000 + 32'(k), 32'h0F0F_00FF, 32'd0, 3'b011);
    end
    expect_res(4'd1, 32'hFFFF_00FE, 5'd3, 1'b1, 1'b0, 6'd0);
    expect_res(4'd3, 32'hFFFF_00FC, 5'd3, 1'b1, 1'b0, 6'd0);
    step();
    commit(4'd2, 1'b1);
    step();
    commit(4'd1, 1'b0);
    step();
    commit(4'd3, 1'b0);
    repeat (6) step();

    // Backpressure: SUB wraps to all-ones and holds while ready is low
    step();
    req.x_result_ready = 1'b0;
    issue(32'h0000_128B, 4'd4, 32'd0, 32'd1, 32'd0, 3'b011);
    commit(4'd4, 1'b0);
    expect_res(4'd4, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 6'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) begin
        check("bp_valid", 64'(resp.x_result_valid), 64'(1));
        check("bp_data", 64'(resp.x_result.data), 64'(32'hFFFF_FFFF));
      end
      if (k == 5) req.x_result_ready = 1'b1;
    end

    // Ten back-to-back committed ADDs wrap the pointers
    for (int i = 0; i < 10; i++) begin
      step();
      issue(mk(3'b000, 5'(i + 1)), 4'(i), 32'(i), 32'd100, 32'd0, 3'b011);
      commit(4'(i), 1'b0);
      expect_res(4'(i), 32'(i + 100), 5'(i + 1), 1'b1, 1'b0, 6'd0);
      #1;
      check("wrap_ready", 64'(resp.x_issue_ready), 64'(1));
    end
    repeat (5) step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    // Reset with a pending result and three queued entries: everything is discarded
    step();
    req.x_result_ready = 1'b0;
    issue(mk(3'b000, 5'd1), 4'd1, 32'd1, 32'd1, 32'd0, 3'b011);
    commit(4'd1, 1'b0);
    for (int k = 2; k < 5; k++) begin
      step();
      issue(mk(3'b000, 5'd1), 4'(k), 32'd1, 32'd1, 32'd0, 3'b011);
    end
    step();
    check("pre_reset_pending", 64'(resp.x_result_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(resp.x_issue_ready), 64'(1));
    check("mid_rst_valid", 64'(resp.x_result_valid), 64'(0));
    check("mid_rst_zero", 64'({resp.x_issue_resp, resp.x_result}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req.x_result_ready = 1'b1;
    step();
    commit(4'd3, 1'b0);
    #1;
    check("post_rst_ready", 64'(resp.x_issue_ready), 64'(1));
    repeat (8) step();
    check("final_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
